ysyx_22041071_axi_rd_arb: RTL and testbench

//  Two-master read arbiter sharing the core's single AXI read port between instruction fetch (req 0) and LSU (req 1).

---
 rtl/ysyx_22041071_axi_rd_arb_pkg.sv | 19 +
 rtl/ysyx_22041071_axi_rd_arb_if.sv | 47 ++++
 rtl/ysyx_22041071_arb_pick.sv | 26 ++
 rtl/ysyx_22041071_axi_rd_arb.sv | 111 +++++++++++
 tb/tb_ysyx_22041071_axi_rd_arb.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041071_axi_rd_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter
// (FSM state codes, requester IDs, default transfer size).
package ysyx_22041071_axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_e;

  localparam logic       ARB_ID_IF  = 1'b0;
  localparam logic       ARB_ID_LSU = 1'b1;
  localparam logic [1:0] SIZE_D     = 2'b11;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ysyx_22041071_axi_rd_arb_if.sv
// Bundle of requester-side (s_*) and downstream-side (m_*) AXI read signals.
// master: arbiter view; slave: requesters plus downstream bridge view.
interface ysyx_22041071_axi_rd_arb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int RESP_W = 2
);
  // valid/ready: a beat transfers on any rising clk edge where both valid and
  // ready are high; a source holds valid and payload until that edge.
  logic [1:0]          s_ar_valid;
  logic [1:0]          s_ar_ready;
  logic [2*ADDR_W-1:0] s_addr;
  logic [2*LEN_W-1:0]  s_len;
  logic [3:0]          s_size;
  logic [1:0]          s_r_valid;
  logic [1:0]          s_r_ready;
  logic [DATA_W-1:0]   s_r_data;
  logic [RESP_W-1:0]   s_r_resp;
  logic                s_r_last;

  logic                m_ar_valid;
  logic                m_ar_ready;
  logic [ADDR_W-1:0]   m_addr;
  logic [LEN_W-1:0]    m_len;
  logic [1:0]          m_size;
  logic                m_r_valid;
  logic                m_r_ready;
  logic [DATA_W-1:0]   m_r_data;
  logic [RESP_W-1:0]   m_r_resp;
  logic                m_r_last;

  modport master (
    input  s_ar_valid, s_addr, s_len, s_size, s_r_ready,
           m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
    output s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_r_last,
           m_ar_valid, m_addr, m_len, m_size, m_r_ready
  );

  modport slave (
    output s_ar_valid, s_addr, s_len, s_size, s_r_ready,
           m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
    input  s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_r_last,
           m_ar_valid, m_addr, m_len, m_size, m_r_ready
  );

endinterface

// File: rtl/ysyx_22041071_arb_pick.sv
// Combinational 2-way picker. YSYX_22041071_ARB_RR_EN selects round-robin;
// otherwise LSU (req 1) has fixed priority over IF (req 0).
module ysyx_22041071_arb_pick
  import ysyx_22041071_axi_rd_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       any_o
);

  assign any_o = |req_i;

`ifdef YSYX_22041071_ARB_RR_EN
  always_comb begin
    grant_o = ARB_ID_IF;
    if (&req_i)              grant_o = ~last_grant_i;
    else if (req_i[ARB_ID_LSU]) grant_o = ARB_ID_LSU;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign grant_o = req_i[ARB_ID_LSU] ? ARB_ID_LSU : ARB_ID_IF;
`endif

endmodule

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// Two-master read arbiter: IF/LSU share one AXI read port, one transaction
// in flight. Arbitration mode set by YSYX_22041071_ARB_RR_EN (see picker).
module ysyx_22041071_axi_rd_arb
  import ysyx_22041071_axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int RESP_W = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  ysyx_22041071_axi_rd_arb_if.master  bus,
  output logic                        arb_err,
  output arb_state_e                  dbg_state_o
);

  arb_state_e        state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              m_ar_valid_q;
  logic              arb_err_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [LEN_W-1:0]  m_len_q;
  logic [1:0]        m_size_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic [LEN_W-1:0]  beat_cnt_d;
  logic              pick_grant;
  logic              pick_any;
  logic              r_hs;

  ysyx_22041071_arb_pick u_pick (
    .req_i        (bus.s_ar_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .any_o        (pick_any)
  );

  assign r_hs       = (state_q == ARB_R) && bus.m_r_valid && bus.s_r_ready[grant_q];
  assign beat_cnt_d = beat_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= ARB_ID_IF;
      last_grant_q <= ARB_ID_IF;
      m_ar_valid_q <= 1'b0;
      arb_err_q    <= 1'b0;
      m_addr_q     <= '0;
      m_len_q      <= '0;
      m_size_q     <= '0;
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (bus.m_r_valid) arb_err_q <= 1'b1;
          if (pick_any) begin
            grant_q      <= pick_grant;
            m_addr_q     <= pick_grant ? bus.s_addr[2*ADDR_W-1:ADDR_W] : bus.s_addr[ADDR_W-1:0];
            m_len_q      <= pick_grant ? bus.s_len[2*LEN_W-1:LEN_W]    : bus.s_len[LEN_W-1:0];
            m_size_q     <= pick_grant ? bus.s_size[3:2]               : bus.s_size[1:0];
            m_ar_valid_q <= 1'b1;
            state_q      <= ARB_AR;
          end
        end
        ARB_AR: begin
          if (bus.m_r_valid) arb_err_q <= 1'b1;
          if (bus.m_ar_ready) begin
            m_ar_valid_q <= 1'b0;
            beat_cnt_q   <= '0;
            state_q      <= ARB_R;
          end
        end
        ARB_R: begin
          if (r_hs) begin
            beat_cnt_q <= beat_cnt_d;
            // A short or long burst still terminates; the mismatch is only flagged.
            if (bus.m_r_last) begin
              state_q      <= ARB_IDLE;
              last_grant_q <= grant_q;
              if (beat_cnt_q != m_len_q) arb_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.s_ar_ready = 2'b00;
    bus.s_r_valid  = 2'b00;
    bus.m_r_ready  = 1'b0;
    if (state_q == ARB_AR && bus.m_ar_ready) bus.s_ar_ready = id_onehot(grant_q);
    if (state_q == ARB_R) begin
      bus.s_r_valid = bus.m_r_valid ? id_onehot(grant_q) : 2'b00;
      bus.m_r_ready = bus.s_r_ready[grant_q];
    end
  end

  assign bus.s_r_data   = bus.m_r_data;
  assign bus.s_r_resp   = bus.m_r_resp;
  assign bus.s_r_last   = bus.m_r_last;
  assign bus.m_ar_valid = m_ar_valid_q;
  assign bus.m_addr     = m_addr_q;
  assign bus.m_len      = m_len_q;
  assign bus.m_size     = m_size_q;
  assign arb_err        = arb_err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// Directed bench for ysyx_22041071_axi_rd_arb with AR and R scoreboards.
// Honors YSYX_22041071_ARB_RR_EN for the expected arbitration order.
module tb_ysyx_22041071_axi_rd_arb;
  import ysyx_22041071_axi_rd_arb_pkg::*;

  logic       clk;
  logic       reset;
  logic       arb_err;
  arb_state_e dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [73:0] ar_exp_q[$];
  logic [67:0] r_exp_q[$];

  logic [63:0] req_addr [2];
  logic [7:0]  req_len  [2];
  logic [1:0]  req_size [2];

  ysyx_22041071_axi_rd_arb_if #(.ADDR_W(64), .DATA_W(64), .LEN_W(8), .RESP_W(2)) bus ();

  ysyx_22041071_axi_rd_arb #(.ADDR_W(64), .DATA_W(64), .LEN_W(8), .RESP_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .arb_err     (arb_err),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.s_ar_valid = 2'b00;
    bus.s_addr     = '0;
    bus.s_len      = '0;
    bus.s_size     = '0;
    bus.s_r_ready  = 2'b00;
    bus.m_ar_ready = 1'b0;
    bus.m_r_valid  = 1'b0;
    bus.m_r_data   = '0;
    bus.m_r_resp   = '0;
    bus.m_r_last   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  // driver tasks
  task automatic req(input int id, input logic [63:0] addr, input logic [7:0] len, input logic [1:0] size);
    bus.s_addr[id*64 +: 64] = addr;
    bus.s_len[id*8 +: 8]    = len;
    bus.s_size[id*2 +: 2]   = size;
    bus.s_ar_valid[id]      = 1'b1;
  endtask

  task automatic ar_phase(input int id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] size, input int stall);
    check("ar_state", dbg_state, ARB_AR);
    check("m_ar_valid_set", bus.m_ar_valid, 1'b1);
    bus.m_ar_ready = 1'b0;
    for (int c = 0; c < stall; c++) begin
      #1;
      check("s_ar_ready_stall", bus.s_ar_ready, 2'b00);
      check("m_payload_stable", {bus.m_addr, bus.m_len, bus.m_size}, {addr, len, size});
      if (c == 0) begin
        bus.s_ar_valid[id]      = 1'b0;
        bus.s_addr[id*64 +: 64] = ~addr;
      end
      step();
    end
    bus.m_ar_ready = 1'b1;
    #1;
    check("s_ar_ready", bus.s_ar_ready, (id == 1) ? 2'b10 : 2'b01);
    ar_exp_q.push_back({addr, len, size});
    step();
    bus.m_ar_ready     = 1'b0;
    bus.s_ar_valid[id] = 1'b0;
    check("r_state", dbg_state, ARB_R);
    check("m_ar_valid_clr", bus.m_ar_valid, 1'b0);
  endtask

  task automatic r_phase(input int id, input int nbeats, input int last_at,
                         input logic [63:0] base, input logic [1:0] resp, input bit toggle);
    int  i;
    int  guard;
    logic rdy;
    logic [63:0] d;
    i = 0;
    guard = 0;
    while (i < nbeats && guard < 64) begin
      rdy = toggle ? ((guard % 2) == 0) : 1'b1;
      d   = base + 64'(i);
      bus.m_r_valid     = 1'b1;
      bus.m_r_data      = d;
      bus.m_r_resp      = resp;
      bus.m_r_last      = (i == last_at);
      bus.s_r_ready     = 2'b00;
      bus.s_r_ready[id] = rdy;
      #1;
      check("s_r_valid_route", bus.s_r_valid, (id == 1) ? 2'b10 : 2'b01);
      check("m_r_ready_mirror", bus.m_r_ready, rdy);
      if (rdy) r_exp_q.push_back({id[0], d, resp, (i == last_at)});
      step();
      if (rdy) i++;
      guard++;
    end
    if (guard >= 64) check("r_phase_timeout", guard, 0);
    bus.m_r_valid = 1'b0;
    bus.m_r_last  = 1'b0;
    bus.s_r_ready = 2'b00;
  endtask

  task automatic run_both(input int first, input logic [1:0] resp_first);
    int second;
    second = 1 - first;
    req(0, req_addr[0], req_len[0], req_size[0]);
    req(1, req_addr[1], req_len[1], req_size[1]);
    step();
    ar_phase(first, req_addr[first], req_len[first], req_size[first], 0);
    r_phase(first, int'(req_len[first]) + 1, int'(req_len[first]), 64'h1000 * (first + 1), resp_first, 1'b0);
    check("idle_between", dbg_state, ARB_IDLE);
    step();
    ar_phase(second, req_addr[second], req_len[second], req_size[second], 0);
    r_phase(second, int'(req_len[second]) + 1, int'(req_len[second]), 64'h2000 * (second + 1), 2'b00, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.m_ar_valid && bus.m_ar_ready) begin
        if (ar_exp_q.size() == 0) begin
          n_total++;
          $display("FAIL ar_unexpected: got addr %0h required no AR", bus.m_addr);
        end else check("ar_payload", {bus.m_addr, bus.m_len, bus.m_size}, ar_exp_q.pop_front());
      end
      if (|(bus.s_r_valid & bus.s_r_ready)) begin
        if (r_exp_q.size() == 0) begin
          n_total++;
          $display("FAIL r_unexpected: got data %0h required no beat", bus.s_r_data);
        end else check("r_beat", {bus.s_r_valid[1], bus.s_r_data, bus.s_r_resp, bus.s_r_last},
                       r_exp_q.pop_front());
      end
    end
  end

  initial begin
    int first_rr;
    req_addr[0] = 64'h8000_0004; req_len[0] = 8'd0; req_size[0] = 2'd2;
    req_addr[1] = 64'h8000_1000; req_len[1] = 8'd1; req_size[1] = 2'd3;
    do_reset();

    // reset values
    check("rst_state", dbg_state, ARB_IDLE);
    check("rst_m_ar_valid", bus.m_ar_valid, 1'b0);
    check("rst_m_payload", {bus.m_addr, bus.m_len, bus.m_size}, 74'd0);
    check("rst_s_ar_ready", bus.s_ar_ready, 2'b00);
    check("rst_s_r_valid", bus.s_r_valid, 2'b00);
    check("rst_m_r_ready", bus.m_r_ready, 1'b0);
    check("rst_arb_err", arb_err, 1'b0);

    // IF only, single beat
    req(0, 64'h8000_0000, 8'd0, SIZE_D);
    bus.m_ar_ready = 1'b1;
    #1;
    check("latency_n", bus.m_ar_valid, 1'b0);
    step();
    ar_phase(0, 64'h8000_0000, 8'd0, SIZE_D, 0);
    r_phase(0, 1, 0, 64'h0000_0013_0000_0093, 2'b00, 1'b0);
    check("if_done_idle", dbg_state, ARB_IDLE);

    // simultaneous requests, last grant IF: LSU wins in both modes
    run_both(1, 2'b00);

    // LSU burst len=3 with AR stall, request dropped in AR, ready toggling
    req(1, 64'h8000_2000, 8'd3, 2'd3);
    step();
    ar_phase(1, 64'h8000_2000, 8'd3, 2'd3, 3);
    r_phase(1, 4, 3, 64'hABCD_0000, 2'b00, 1'b1);
    check("burst_idle", dbg_state, ARB_IDLE);
    check("burst_no_err", arb_err, 1'b0);

    // simultaneous requests, last grant LSU; SLVERR forwarded on first
`ifdef YSYX_22041071_ARB_RR_EN
    first_rr = 0;
`else
    first_rr = 1;
`endif
    run_both(first_rr, 2'b10);
    check("both_no_err", arb_err, 1'b0);

    // early r_last: error flagged, transaction still ends
    req(1, 64'h8000_3000, 8'd3, 2'd3);
    step();
    ar_phase(1, 64'h8000_3000, 8'd3, 2'd3, 0);
    r_phase(1, 3, 2, 64'h5500, 2'b00, 1'b0);
    check("early_last_idle", dbg_state, ARB_IDLE);
    check("early_last_err", arb_err, 1'b1);
    do_reset();
    check("err_cleared", arb_err, 1'b0);

    // stray R beat while idle
    bus.m_r_valid = 1'b1;
    bus.s_r_ready = 2'b11;
    #1;
    check("stray_m_r_ready", bus.m_r_ready, 1'b0);
    check("stray_s_r_valid", bus.s_r_valid, 2'b00);
    step();
    bus.m_r_valid = 1'b0;
    bus.s_r_ready = 2'b00;
    check("stray_err", arb_err, 1'b1);
    do_reset();

    // reset mid-burst
    req(1, 64'h8000_4000, 8'd3, 2'd3);
    step();
    ar_phase(1, 64'h8000_4000, 8'd3, 2'd3, 0);
    r_phase(1, 2, 99, 64'h7700, 2'b00, 1'b0);
    check("mid_burst_state", dbg_state, ARB_R);
    bus.m_r_valid = 1'b1;
    reset = 1'b1;
    step();
    check("mid_rst_state", dbg_state, ARB_IDLE);
    check("mid_rst_m_ar_valid", bus.m_ar_valid, 1'b0);
    check("mid_rst_s_r_valid", bus.s_r_valid, 2'b00);
    check("mid_rst_m_r_ready", bus.m_r_ready, 1'b0);
    bus.m_r_valid = 1'b0;
    reset = 1'b0;
    step();
    check("post_rst_state", dbg_state, ARB_IDLE);
    check("post_rst_err", arb_err, 1'b0);

    // final report
    check("ar_queue_drained", ar_exp_q.size(), 0);
    check("r_queue_drained", r_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
